// File: rtl/ntt_pkg.sv
// Shared NTT constants and types (Kyber parameter set, Montgomery R = 2^16).
package ntt_pkg;

  localparam int unsigned DATA_WIDTH    = 12;
  localparam int unsigned Q             = 3329;
  localparam int unsigned MUL_STAGE_CNT = 3;

  // Montgomery radix bits and -Q^-1 mod 2^MONT_R_BITS
  localparam int unsigned MONT_R_BITS   = 16;
  localparam int unsigned MONT_QNEG_INV = 3327;

  typedef logic [DATA_WIDTH-1:0] coef_t;

  // n^-1 = 128^-1 = 3303 = 2^-7 mod Q; Montgomery form 2^-7 * 2^16 = 2^9
  localparam coef_t INTT_SCALE = coef_t'(512);

endpackage

// File: rtl/mo_mul.sv
// Pipelined Montgomery multiplier: p = a * b * R^-1 mod Q, fully reduced to [0, Q).
// Three register stages, matching MUL_STAGE_CNT.
module mo_mul
  import ntt_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  coef_t a,
  input  coef_t b,
  output coef_t p
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned RB    = MONT_R_BITS;
  // t < Q^2 < 2^(RB+DATA_WIDTH), m*Q < 2^(RB+DATA_WIDTH); one extra bit for the sum
  localparam int unsigned SumW  = RB + DATA_WIDTH + 1;
  localparam int unsigned UW    = SumW - RB;

  logic [ProdW-1:0] prod_q, t_q;
  logic [RB-1:0]    m_d, m_q;
  logic [SumW-1:0]  sum;
  logic [UW-1:0]    u, u_red;
  coef_t            p_q;

  // Reduction arithmetic between the pipeline registers
  always_comb begin
    m_d   = prod_q[RB-1:0] * RB'(MONT_QNEG_INV);
    sum   = SumW'(t_q) + SumW'(m_q) * SumW'(Q);
    u     = UW'(sum >> RB);
    u_red = (u >= UW'(Q)) ? u - UW'(Q) : u;
  end

  // Stage 1 product, stage 2 quotient, stage 3 reduced result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      t_q    <= '0;
      m_q    <= '0;
      p_q    <= '0;
    end else begin
      prod_q <= ProdW'(a) * ProdW'(b);
      t_q    <= prod_q;
      m_q    <= m_d;
      p_q    <= coef_t'(u_red);
    end
  end

  assign p = p_q;

endmodule

// File: rtl/pair_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a write while full is accepted only
// when a read happens in the same cycle.
module pair_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  // Status flags and accepted-operation strobes
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd = rd && !empty;
    do_wr = wr && (!full || do_rd);
    rdata = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/intt_scale_out.sv
// INTT output stage: scales both lanes by n^-1, buffers pairs and serialises them
// into a single-lane valid/ready stream with coefficient index and last flag.
module intt_scale_out
  import ntt_pkg::*;
#(
  parameter int unsigned N_COEF      = 256,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter coef_t       SCALE_CONST = INTT_SCALE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_en,
  input  logic [2*DATA_WIDTH-1:0]   in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(N_COEF)-1:0] out_idx,
  output logic                      out_last,
  output logic                      ovf,
  output logic                      busy
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned IdxW = $clog2(N_COEF);

  coef_t                prod0, prod1;
  logic [MUL_STAGE_CNT-1:0] en_sr_q;
  logic                 wr;
  logic [2*W-1:0]       head;
  logic                 full, empty;
  logic                 fire, pop;
  logic                 sel_q, sel_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 ovf_q, ovf_d;

  mo_mul u_mul0 (
    .clk (clk),
    .rst (rst),
    .a   (SCALE_CONST),
    .b   (in[W-1:0]),
    .p   (prod0)
  );

  mo_mul u_mul1 (
    .clk (clk),
    .rst (rst),
    .a   (SCALE_CONST),
    .b   (in[2*W-1:W]),
    .p   (prod1)
  );

  // Enable delay line, aligned with the multiplier outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) en_sr_q <= '0;
    else      en_sr_q <= {en_sr_q[MUL_STAGE_CNT-2:0], in_en};
  end

  assign wr = en_sr_q[MUL_STAGE_CNT-1];

  pair_fifo #(
    .WIDTH (2 * W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .wdata ({prod1, prod0}),
    .rd    (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Handshake decode and lane/index/overflow next state
  always_comb begin
    fire  = !empty && out_ready;
    pop   = fire && sel_q;
    sel_d = sel_q;
    idx_d = idx_q;
    ovf_d = ovf_q;
    if (fire) begin
      sel_d = !sel_q;
      idx_d = (idx_q == IdxW'(N_COEF - 1)) ? '0 : idx_q + IdxW'(1);
    end
    // a pair landing on a full buffer is lost unless the head leaves this cycle
    if (wr && full && !pop) ovf_d = 1'b1;
  end

  // Lane select, index counter and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= 1'b0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end

  // Output view of the head entry; data forced to 0 while empty
  always_comb begin
    out_valid = !empty;
    out_data  = empty ? '0 : (sel_q ? head[2*W-1:W] : head[W-1:0]);
    out_idx   = idx_q;
    out_last  = !empty && (idx_q == IdxW'(N_COEF - 1));
    ovf       = ovf_q;
    busy      = (|en_sr_q) || !empty;
  end

endmodule

// File: tb/tb_intt_scale_out.sv
// Scoreboard bench for intt_scale_out: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares on every handshake.
module tb_intt_scale_out;
  import ntt_pkg::*;

  localparam int unsigned N_COEF     = 256;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned W          = DATA_WIDTH;
  localparam int unsigned IdxW       = $clog2(N_COEF);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_en = 1'b0;
  logic [2*W-1:0]    in_pair = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [IdxW-1:0]   out_idx;
  logic              out_last;
  logic              ovf;
  logic              busy;

  intt_scale_out #(
    .N_COEF     (N_COEF),
    .FIFO_DEPTH (FIFO_DEPTH),
    .SCALE_CONST(INTT_SCALE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in        (in_pair),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]    data;
    logic [IdxW-1:0] idx;
    logic            last;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt      = 0;
  int   err_cnt      = 0;
  int   exp_idx      = 0;
  int   mon_words    = 0;
  int   pairs_issued = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted word must be the oldest expected one
  always @(negedge clk) begin
    if (rst && out_valid === 1'b1 && out_ready) begin
      exp_t e;
      mon_words++;
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_word: got data %0d idx %0d, required no word", out_data,
                 out_idx);
      end else begin
        e = exp_q.pop_front();
        check("word_data", 32'(out_data), 32'(e.data));
        check("word_idx",  32'(out_idx),  32'(e.idx));
        check("word_last", 32'(out_last), 32'(e.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] enc(input int v);
    return W'((128 * v) % Q);
  endfunction

  function automatic void push_exp(input logic [W-1:0] d);
    exp_q.push_back('{data: d, idx: IdxW'(exp_idx), last: (exp_idx == N_COEF - 1)});
    exp_idx = (exp_idx + 1) % N_COEF;
  endfunction

  // One pair on the INTT side for one cycle; keep=0 means the pair will be dropped
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ea, input logic [W-1:0] eb, input bit keep);
    if (keep) begin
      push_exp(ea);
      push_exp(eb);
    end
    in_pair = {b, a};
    in_en   = 1'b1;
    step();
    in_en   = 1'b0;
    in_pair = 2*W'($urandom);
    pairs_issued++;
  endtask

  // Pairs spaced two cycles apart, values base+2j+k
  task automatic burst(input int npairs, input int base, input int nkeep);
    for (int j = 0; j < npairs; j++) begin
      int v0;
      v0 = base + 2 * j;
      send(enc(v0), enc(v0 + 1), W'(v0 % Q), W'((v0 + 1) % Q), j < nkeep);
      step();
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 1000) begin
      step();
      n++;
    end
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_en = 1'b0;
    exp_q.delete();
    exp_idx = 0;
    mon_words = 0;
    pairs_issued = 0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    int seen;
    int val;
    int added;
    int n;

    // Reset with random inputs
    repeat (4) begin
      in_en     = 1'($urandom_range(0, 1));
      in_pair   = 2*W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data",  32'(out_data),  0);
    check("rst_idx",   32'(out_idx),   0);
    check("rst_last",  32'(out_last),  0);
    check("rst_ovf",   32'(ovf),       0);
    check("rst_busy",  32'(busy),      0);
    in_en = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    seen = 0;
    repeat (10) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    check("idle_no_valid", seen, 0);

    // Single pair: latency MUL_STAGE_CNT+1, values 1 and 2
    send(12'd128, 12'd256, 12'd1, 12'd2, 1'b1);
    for (int c = 1; c <= int'(MUL_STAGE_CNT) + 1; c++) begin
      if (c > 1) step();
      check($sformatf("latency_c%0d", c), 32'(out_valid), 32'(c == int'(MUL_STAGE_CNT) + 1));
    end
    wait_idle("single");

    // Hand vectors: 3303*x mod Q; idx continues across gaps
    send(12'd3328, 12'd1,    12'd26, 12'd3303, 1'b1);
    repeat (3) step();
    send(12'd0,    12'd3328, 12'd0,  12'd26,   1'b1);
    step();
    send(12'd1664, 12'd2,    12'd13, 12'd3277, 1'b1);
    wait_idle("directed");
    check("directed_idx", 32'(out_idx), 8);

    // Full polynomial with ready always high
    do_reset();
    out_ready = 1'b1;
    burst(N_COEF / 2, 0, N_COEF / 2);
    wait_idle("burst");
    check("burst_ovf", 32'(ovf), 0);
    check("burst_idx_wrap", 32'(out_idx), 0);

    // Consumer stalled for the whole burst: first 16 pairs kept, rest dropped
    do_reset();
    out_ready = 1'b0;
    burst(FIFO_DEPTH, 5, FIFO_DEPTH);
    repeat (6) step();
    check("stall_ovf_before", 32'(ovf), 0);
    check("stall_valid", 32'(out_valid), 1);
    check("stall_hold_data", 32'(out_data), 5);
    check("stall_hold_idx", 32'(out_idx), 0);
    burst(N_COEF / 2 - FIFO_DEPTH, 5 + 2 * FIFO_DEPTH, 0);
    repeat (4) step();
    check("stall_ovf_after", 32'(ovf), 1);
    out_ready = 1'b1;
    wait_idle("stall_drain");
    check("stall_words", mon_words, 2 * FIFO_DEPTH);
    check("stall_ovf_sticky", 32'(ovf), 1);

    // Fill to exactly full, then a write coinciding with a pop
    do_reset();
    check("reset_clears_ovf", 32'(ovf), 0);
    out_ready = 1'b0;
    burst(FIFO_DEPTH, 300, FIFO_DEPTH);
    repeat (4) step();
    out_ready = 1'b1;          // accept lane 0 of the head only
    step();
    out_ready = 1'b0;
    val = 300 + 2 * FIFO_DEPTH;
    send(enc(val), enc(val + 1), W'(val), W'(val + 1), 1'b1);
    val += 2;
    step();
    step();
    out_ready = 1'b1;          // write lands this cycle; pop lane 1 in the same edge
    step();
    out_ready = 1'b0;
    step();
    check("full_wr_pop_ovf", 32'(ovf), 0);
    // Random ready around the boundary, never exceeding 16 stored pairs
    added = 0;
    n = 0;
    while (added < 48 && n < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (pairs_issued - mon_words / 2 < int'(FIFO_DEPTH) && $urandom_range(0, 1) == 1) begin
        send(enc(val), enc(val + 1), W'(val), W'(val + 1), 1'b1);
        val += 2;
        added++;
      end else begin
        step();
      end
      n++;
    end
    check("random_issued", added, 48);
    out_ready = 1'b1;
    wait_idle("random");
    check("random_ovf", 32'(ovf), 0);
    check("random_words", mon_words, 2 * (FIFO_DEPTH + 1 + 48));

    // Reset in the middle of a burst, then a fresh polynomial
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < int'(N_COEF / 2) && mon_words < 100; j++) begin
      send(enc(2 * j), enc(2 * j + 1), W'(2 * j), W'(2 * j + 1), 1'b1);
      step();
    end
    check("midrst_reached", 32'(mon_words >= 100), 1);
    rst = 1'b0;
    exp_q.delete();
    exp_idx = 0;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_idx",   32'(out_idx),   0);
    check("midrst_data",  32'(out_data),  0);
    check("midrst_busy",  32'(busy),      0);
    step();
    step();
    rst = 1'b1;
    mon_words = 0;
    pairs_issued = 0;
    step();
    burst(8, 40, 8);
    wait_idle("midrst_fresh");
    check("midrst_fresh_words", mon_words, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
